serial_mmio_responder: RTL and testbench

//  Bus-side responder for the CPU serial-port window (data at offset 0x8, status at 0xC).

---
 rtl/serial_mmio_responder_if.sv | 12 +
 rtl/serial_mmio_responder.sv | 148 ++++++++++++++
 tb/tb_serial_mmio_responder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_mmio_responder_if.sv
// CPU-side bus for the serial window: one-cycle access strobe, store data,
// and combinational load data returned in the same cycle.
interface serial_mmio_responder_if;
   logic        ce_i;
   logic        we_i;
   logic [3:0]  addr_i;
   logic [7:0]  wdata_i;
   logic [31:0] rdata_o;

   modport master (output ce_i, we_i, addr_i, wdata_i, input rdata_o);
   modport slave  (input ce_i, we_i, addr_i, wdata_i, output rdata_o);
endinterface

// File: rtl/serial_mmio_responder.sv
// Serial-port MMIO responder: data register at 0x8, status register at 0xC.
// Buffers received bytes in an RX FIFO and store data in a TX FIFO, and
// feeds the transmitter one byte at a time through a small start/busy FSM.
module serial_mmio_responder #(
   parameter int RX_AW        = 3,
   parameter int TX_AW        = 3,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   serial_mmio_responder_if.slave  bus,
   input  logic                    rx_ready_i,
   input  logic [7:0]              rx_data_i,
   input  logic                    tx_busy_i,
   output logic                    tx_start_o,
   output logic [7:0]              tx_data_o,
   output logic                    irq_o
);

   localparam int RX_DEPTH = 1 << RX_AW;
   localparam int TX_DEPTH = 1 << TX_AW;
   localparam int TW       = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_START  = 2'd1;
   localparam logic [1:0] S_WAITHI = 2'd2;
   localparam logic [1:0] S_WAITLO = 2'd3;

   // storage and registered state
   logic [7:0]     rx_mem_q [RX_DEPTH];
   logic [7:0]     tx_mem_q [TX_DEPTH];
   logic [RX_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [TX_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [RX_AW:0] rx_count_q, rx_count_d;
   logic [TX_AW:0] tx_count_q, tx_count_d;
   logic           rxovr_q, rxovr_d, txdrop_q, txdrop_d;
   logic [1:0]     state_q, state_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [7:0]     tx_data_q, tx_data_d;

   // decoded access and FIFO events
   logic ld_data, ld_stat, st_data;
   logic rx_empty, rx_full, rx_push, rx_pop;
   logic tx_full, tx_push, tx_pop;

   // The count never exceeds the depth, so its top bit alone marks "full".
   assign rx_empty = (rx_count_q == '0);
   assign rx_full  = rx_count_q[RX_AW];
   assign tx_full  = tx_count_q[TX_AW];

   // Access decode, FIFO bookkeeping, sticky flags and the TX FSM.
   always_comb begin
      ld_data = bus.ce_i & ~bus.we_i & (bus.addr_i == 4'h8);
      ld_stat = bus.ce_i & ~bus.we_i & (bus.addr_i == 4'hC);
      st_data = bus.ce_i &  bus.we_i & (bus.addr_i == 4'h8);

      // A pop frees a slot in the same cycle, so a push on a full FIFO with
      // a concurrent pop is accepted and is not an overrun.
      rx_pop  = ld_data & ~rx_empty;
      rx_push = rx_ready_i & (~rx_full | rx_pop);
      // TX fullness is judged before the FSM pop, so a store on full drops.
      tx_push = st_data & ~tx_full;
      tx_pop  = (state_q == S_IDLE) & (tx_count_q != '0) & ~tx_busy_i;

      rx_wp_d    = rx_wp_q + RX_AW'(rx_push);
      rx_rp_d    = rx_rp_q + RX_AW'(rx_pop);
      rx_count_d = rx_count_q + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);
      tx_wp_d    = tx_wp_q + TX_AW'(tx_push);
      tx_rp_d    = tx_rp_q + TX_AW'(tx_pop);
      tx_count_d = tx_count_q + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);

      // Setting beats a status-read clear in the same cycle.
      rxovr_d  = (rx_ready_i & rx_full & ~rx_pop) | (rxovr_q & ~ld_stat);
      txdrop_d = (st_data & tx_full) | (txdrop_q & ~ld_stat);

      state_d   = state_q;
      timer_d   = timer_q;
      tx_data_d = tx_data_q;
      case (state_q)
         S_IDLE: begin
            if (tx_pop) begin
               tx_data_d = tx_mem_q[tx_rp_q];
               state_d   = S_START;
            end
         end
         S_START: begin
            timer_d = '0;
            state_d = S_WAITHI;
         end
         S_WAITHI: begin
            // Give up on a transmitter that never acknowledges; the byte is lost.
            if (tx_busy_i)                                state_d = S_WAITLO;
            else if (timer_q == TW'(BUSY_TIMEOUT - 1))    state_d = S_IDLE;
            else                                          timer_d = timer_q + 1'b1;
         end
         default: begin
            if (!tx_busy_i) state_d = S_IDLE;
         end
      endcase
   end

   // Load data mux; stores and unmapped offsets read as zero.
   always_comb begin
      bus.rdata_o = '0;
      if (ld_data && !rx_empty) bus.rdata_o = {24'b0, rx_mem_q[rx_rp_q]};
      else if (ld_stat)         bus.rdata_o = {28'b0, txdrop_q, rxovr_q, ~rx_empty, ~tx_full};
   end

   // FIFO storage; contents need no reset since pointers and counts define validity.
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem_q[rx_wp_q] <= rx_data_i;
      if (tx_push) tx_mem_q[tx_wp_q] <= bus.wdata_i;
   end

   // Control state with synchronous reset; reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wp_q    <= '0;
         rx_rp_q    <= '0;
         rx_count_q <= '0;
         tx_wp_q    <= '0;
         tx_rp_q    <= '0;
         tx_count_q <= '0;
         rxovr_q    <= 1'b0;
         txdrop_q   <= 1'b0;
         state_q    <= S_IDLE;
         timer_q    <= '0;
         tx_data_q  <= '0;
      end else begin
         rx_wp_q    <= rx_wp_d;
         rx_rp_q    <= rx_rp_d;
         rx_count_q <= rx_count_d;
         tx_wp_q    <= tx_wp_d;
         tx_rp_q    <= tx_rp_d;
         tx_count_q <= tx_count_d;
         rxovr_q    <= rxovr_d;
         txdrop_q   <= txdrop_d;
         state_q    <= state_d;
         timer_q    <= timer_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign tx_start_o = (state_q == S_START);
   assign tx_data_o  = tx_data_q;
   assign irq_o      = ~rx_empty;

endmodule

// File: tb/tb_serial_mmio_responder.sv
// Directed bench for serial_mmio_responder: a per-cycle vector table for the
// basic register map plus hand sequences for FIFO limits and the TX FSM.
module tb_serial_mmio_responder;
   logic       clk = 1'b0;
   logic       rst;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       irq;

   always #5 clk = ~clk;

   serial_mmio_responder_if bus ();

   serial_mmio_responder #(.RX_AW(3), .TX_AW(3), .BUSY_TIMEOUT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .rx_ready_i (rx_ready),
      .rx_data_i  (rx_data),
      .tx_busy_i  (tx_busy),
      .tx_start_o (tx_start),
      .tx_data_o  (tx_data),
      .irq_o      (irq)
   );

   int nerr = 0;
   int nchk = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Transmitter model: busy rises 2 cycles after a start pulse and stays 20 cycles.
   logic stall    = 1'b0;
   logic model_on = 1'b0;
   int   mcnt     = 0;
   always @(posedge clk) begin
      if (model_on && tx_start) mcnt <= 22;
      else if (mcnt > 0)        mcnt <= mcnt - 1;
   end
   assign tx_busy = stall | (mcnt > 0 && mcnt <= 20);

   // Start-pulse monitor.
   int         cyc = 0;
   int         starts = 0;
   logic [7:0] sdata[$];
   int         scyc[$];
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (tx_start === 1'b1) begin
         starts++;
         sdata.push_back(tx_data);
         scyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      bus.ce_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = 4'h0; bus.wdata_i = 8'h00;
   endtask

   task automatic load(input logic [3:0] a, output logic [31:0] rd);
      bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a;
      @(negedge clk);
      rd = bus.rdata_o;
      tick();
      idle_bus();
   endtask

   task automatic store(input logic [3:0] a, input logic [7:0] d);
      bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.wdata_i = d;
      tick();
      idle_bus();
   endtask

   task automatic rx_push(input logic [7:0] d);
      rx_ready = 1'b1; rx_data = d;
      tick();
      rx_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; rx_ready = 1'b0; rx_data = 8'h00;
      idle_bus();
      tick();
      tick();
      rst = 1'b0;
      starts = 0;
      sdata.delete();
      scyc.delete();
   endtask

   typedef struct {
      logic        ce;
      logic        we;
      logic [3:0]  addr;
      logic [7:0]  wd;
      logic        rxr;
      logic [7:0]  rxd;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vt[12];

   initial begin
      logic [31:0] rd;
      bit          done;

      //             ce  we  addr  wd     rxr  rxd    rdata  irq
      vt[0]  = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'h41, 32'h00, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 4'hC, 8'h00, 1'b0, 8'h00, 32'h03, 1'b1};
      vt[2]  = '{1'b1, 1'b0, 4'h8, 8'h00, 1'b0, 8'h00, 32'h41, 1'b1};
      vt[3]  = '{1'b1, 1'b0, 4'hC, 8'h00, 1'b0, 8'h00, 32'h01, 1'b0};
      vt[4]  = '{1'b1, 1'b1, 4'hC, 8'hFF, 1'b0, 8'h00, 32'h00, 1'b0};
      vt[5]  = '{1'b1, 1'b0, 4'h4, 8'h00, 1'b0, 8'h00, 32'h00, 1'b0};
      vt[6]  = '{1'b1, 1'b0, 4'h8, 8'h00, 1'b0, 8'h00, 32'h00, 1'b0};
      vt[7]  = '{1'b1, 1'b0, 4'hC, 8'h00, 1'b0, 8'h00, 32'h01, 1'b0};
      vt[8]  = '{1'b1, 1'b0, 4'h8, 8'h00, 1'b1, 8'h99, 32'h00, 1'b0};
      vt[9]  = '{1'b0, 1'b0, 4'h8, 8'h00, 1'b0, 8'h00, 32'h00, 1'b1};
      vt[10] = '{1'b1, 1'b0, 4'h8, 8'h00, 1'b0, 8'h00, 32'h99, 1'b1};
      vt[11] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 32'h00, 1'b0};

      // Reset state
      do_reset();
      @(negedge clk);
      check("rst tx_start", {31'b0, tx_start}, 32'h0);
      check("rst tx_data", {24'b0, tx_data}, 32'h0);
      check("rst irq", {31'b0, irq}, 32'h0);
      check("rst rdata idle", bus.rdata_o, 32'h0);
      tick();
      load(4'hC, rd); check("rst status", rd, 32'h1);

      // Table: single RX byte round trip, ignored/unmapped accesses, push+pop on empty
      for (int i = 0; i < 12; i++) begin
         bus.ce_i = vt[i].ce; bus.we_i = vt[i].we; bus.addr_i = vt[i].addr; bus.wdata_i = vt[i].wd;
         rx_ready = vt[i].rxr; rx_data = vt[i].rxd;
         @(negedge clk);
         check($sformatf("vec%0d rdata", i), bus.rdata_o, vt[i].exp_rd);
         check($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, vt[i].exp_irq});
         tick();
      end
      idle_bus(); rx_ready = 1'b0;

      // RX overrun on 9th byte, FIFO order, flag clears on read
      do_reset();
      for (int i = 0; i < 9; i++) rx_push(8'(i));
      load(4'hC, rd); check("T2 ovr status", rd, 32'h7);
      for (int i = 0; i < 8; i++) begin
         load(4'h8, rd); check($sformatf("T2 pop%0d", i), rd, 32'(i));
      end
      load(4'hC, rd); check("T2 status after", rd, 32'h1);
      check("T2 irq low", {31'b0, irq}, 32'h0);

      // Overrun set coincident with status read: the set wins
      do_reset();
      for (int i = 0; i < 8; i++) rx_push(8'h20 + 8'(i));
      bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 4'hC;
      rx_ready = 1'b1; rx_data = 8'hEE;
      @(negedge clk);
      check("setwins pre", bus.rdata_o, 32'h3);
      tick();
      idle_bus(); rx_ready = 1'b0;
      load(4'hC, rd); check("setwins set", rd, 32'h7);
      load(4'hC, rd); check("setwins clr", rd, 32'h3);

      // Push coincident with pop on full RX: no overrun, count stays at depth
      do_reset();
      for (int i = 0; i < 8; i++) rx_push(8'h10 + 8'(i));
      bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 4'h8;
      rx_ready = 1'b1; rx_data = 8'hAA;
      @(negedge clk);
      check("T5 oldest", bus.rdata_o, 32'h10);
      tick();
      idle_bus(); rx_ready = 1'b0;
      load(4'hC, rd); check("T5 no ovr", rd, 32'h3);
      for (int i = 1; i < 8; i++) begin
         load(4'h8, rd); check($sformatf("T5 pop%0d", i), rd, 32'h10 + 32'(i));
      end
      load(4'h8, rd); check("T5 pushed", rd, 32'hAA);
      load(4'h8, rd); check("T5 empty", rd, 32'h0);

      // Single byte transmit with a responsive transmitter
      do_reset();
      model_on = 1'b1;
      store(4'h8, 8'h55);
      repeat (12) tick();
      check("T3 data held", {24'b0, tx_data}, 32'h55);
      check("T3 busy seen", {31'b0, tx_busy}, 32'h1);
      repeat (28) tick();
      check("T3 starts", 32'(starts), 32'd1);
      check("T3 byte", (sdata.size() > 0) ? {24'b0, sdata[0]} : 32'hFFFF_FFFF, 32'h55);
      store(4'h8, 8'h66);
      repeat (40) tick();
      check("T3 idle again", 32'(starts), 32'd2);

      // Busy never rises: FSM times out and accepts the next byte
      model_on = 1'b0;
      starts = 0; sdata.delete(); scyc.delete();
      store(4'h8, 8'h77);
      repeat (12) tick();
      check("timeout first", 32'(starts), 32'd1);
      store(4'h8, 8'h78);
      repeat (12) tick();
      check("timeout second", 32'(starts), 32'd2);
      check("timeout byte", (sdata.size() > 1) ? {24'b0, sdata[1]} : 32'hFFFF_FFFF, 32'h78);

      // TX overflow while stalled, then ordered drain with full busy windows
      do_reset();
      stall = 1'b1;
      for (int i = 0; i < 9; i++) store(4'h8, 8'hA0 + 8'(i));
      load(4'hC, rd); check("T4 drop status", rd, 32'h8);
      load(4'hC, rd); check("T4 drop clr", rd, 32'h0);
      check("T4 no start", 32'(starts), 32'd0);
      model_on = 1'b1;
      stall = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         tick();
         if (starts >= 8) done = 1'b1;
      end
      repeat (40) tick();
      check("T4 starts", 32'(starts), 32'd8);
      for (int i = 0; i < sdata.size(); i++)
         check($sformatf("T4 byte%0d", i), {24'b0, sdata[i]}, 32'hA0 + 32'(i));
      for (int i = 1; i < scyc.size(); i++)
         check($sformatf("T4 gap%0d", i), {31'b0, (scyc[i] - scyc[i-1]) >= 22}, 32'h1);

      // Reset during WAITLO with bytes queued
      do_reset();
      store(4'h8, 8'hB0);
      store(4'h8, 8'hB1);
      store(4'h8, 8'hB2);
      store(4'h8, 8'hB3);
      repeat (10) tick();
      check("T6 busy before rst", {31'b0, tx_busy}, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("T6 start low", {31'b0, tx_start}, 32'h0);
      tick();
      load(4'hC, rd); check("T6 status", rd, 32'h1);
      repeat (60) tick();
      check("T6 no restart", 32'(starts), 32'd1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
